// File: rtl/alu_mul_seq_pkg.sv
// Shared constants for the sequential shift-and-add multiplier and its ALU.
package alu_mul_seq_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 4;

    // ALU control word, MSB first: zx, nx, zy, ny, f, no
    localparam logic [5:0] ALU_CTL_ADD   = 6'b000010;
    localparam logic [5:0] ALU_CTL_PASSX = 6'b001100;

    // Last shift step; the update made at this count ends the operation
    localparam logic [CNT_W-1:0] CNT_LAST = 4'd15;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// Team 16-bit ALU: optional zero/negate on each operand, add or AND, optional
// negate of the result, plus zero and negative flags.
module alu_mul_seq_alu
    import alu_mul_seq_pkg::*;
(
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [5:0]       i_ctl,
    output logic [WIDTH-1:0] o_out,
    output logic             o_zr,
    output logic             o_ng
);

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_f;

    // Operand conditioning, function select and output negation
    always_comb begin
        w_x = i_ctl[5] ? '0 : i_x;
        w_x = i_ctl[4] ? ~w_x : w_x;
        w_y = i_ctl[3] ? '0 : i_y;
        w_y = i_ctl[2] ? ~w_y : w_y;
        w_f = i_ctl[1] ? (w_x + w_y) : (w_x & w_y);
        o_out = i_ctl[0] ? ~w_f : w_f;
        o_zr  = (o_out == '0);
        o_ng  = o_out[WIDTH-1];
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential 16x16 -> 16 multiplier. Shift-and-add over up to 16 steps,
// reusing the shared ALU both for accumulation and for the final flag pass.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             zr,
    output logic             ng
);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_product;
    logic             r_zr;
    logic             r_ng;

    logic [5:0]       w_alu_ctl;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_alu_zr;
    logic             w_alu_ng;

    // ALU adds acc+mcand except in DONE, where it passes acc to derive flags
    always_comb begin
        w_alu_ctl = (r_state == ST_DONE) ? ALU_CTL_PASSX : ALU_CTL_ADD;
    end

    alu_mul_seq_alu u_alu (
        .i_x   (r_acc),
        .i_y   (r_mcand),
        .i_ctl (w_alu_ctl),
        .o_out (w_alu_out),
        .o_zr  (w_alu_zr),
        .o_ng  (w_alu_ng)
    );

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_zr      <= 1'b0;
            r_ng      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // No multiplier bits left means no further additions
                    if (r_mplier == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        if (r_mplier[0]) begin
                            r_acc <= w_alu_out;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 4'd1;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_product <= w_alu_out;
                    r_zr      <= w_alu_zr;
                    r_ng      <= w_alu_ng;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded from state
    always_comb begin
        busy    = (r_state == ST_RUN) || (r_state == ST_DONE);
        done    = (r_state == ST_DONE);
        product = r_product;
        zr      = r_zr;
        ng      = r_ng;
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed cases, abort/back-to-back
// cases and randomized operands against an arithmetic reference model.
module tb_alu_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        zr;
    logic        ng;

    int n_total;
    int n_bad;

    alu_mul_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zr      (zr),
        .ng      (ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Edges from the accepting edge to DONE: one per remaining multiplier bit
    // up to its highest set bit, one more to notice it is exhausted, capped at 16.
    function automatic int exp_latency(input logic [15:0] mb);
        int top;
        if (mb == 16'd0) return 1;
        top = 0;
        for (int i = 0; i < 16; i++) if (mb[i]) top = i;
        return (top + 2 > 16) ? 16 : top + 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full multiply; optionally pulses start mid-RUN (must be ignored).
    // Leaves the bench one step into the IDLE cycle after DONE.
    task automatic mul(input logic [15:0] ta, input logic [15:0] tb, input bit poke);
        logic [31:0] full;
        logic [15:0] ep;
        int          lat;
        int          el;
        full = 32'(ta) * 32'(tb);
        ep   = full[15:0];
        el   = exp_latency(tb);
        start = 1'b1;
        a = ta;
        b = tb;
        tick();
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        chk("busy_after_e0", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            start = (poke && lat == 1) ? 1'b1 : 1'b0;
            tick();
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, el);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        tick();
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("product", {16'd0, product}, {16'd0, ep});
        chk("zr", {31'd0, zr}, {31'd0, (ep == 16'd0)});
        chk("ng", {31'd0, ng}, {31'd0, ep[15]});
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] held;
        bit          saw_done;
        n_total = 0;
        n_bad   = 0;
        rst_n = 1'b0;
        start = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        // Reset wins over a simultaneous start
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_product", {16'd0, product}, 32'd0);
        chk("rst_zr", {31'd0, zr}, 32'd0);
        chk("rst_ng", {31'd0, ng}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        mul(16'd3, 16'd5, 1'b0);
        mul(16'h1234, 16'h0000, 1'b0);
        mul(16'hFFFD, 16'd5, 1'b1);
        mul(16'hFFFF, 16'hFFFF, 1'b1);
        mul(16'd7, 16'h8000, 1'b0);

        // Product held across idle cycles
        held = product;
        tick();
        tick();
        chk("product_hold", {16'd0, product}, {16'd0, held});

        // Abort at E5 of a long multiply
        start = 1'b1;
        a = 16'd7;
        b = 16'h8000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_product", {16'd0, product}, 32'd0);
        chk("abort_flags", {30'd0, zr, ng}, 32'd0);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);

        // Randomized, mostly back-to-back
        for (int k = 0; k < 40; k++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'd0;
                1: rb = 16'($urandom) >> $urandom_range(0, 15);
                2: rb = 16'd1 << $urandom_range(0, 15);
                default: rb = 16'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) tick();
            mul(ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
